// File: rtl/kws_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : kws_pkg                                                         |
// | Purpose  : Shared defaults and width helpers for the keyword-spotting      |
// |            audio frame buffer and its storage FIFO.                        |
// | Contents : c_default_* parameter defaults, ch_width(), level_width()      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package kws_pkg;

    localparam int c_default_sample_w  = 16;
    localparam int c_default_n_ch      = 2;
    localparam int c_default_depth     = 32;
    localparam int c_default_frame_len = 16;

    // A channel tag is at least one bit wide, even for a single channel.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // The occupancy must reach DEPTH itself, so it needs one extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : kws_pkg
`default_nettype wire

// File: rtl/kws_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : kws_sync_fifo                                                   |
// | Purpose  : Single-clock FIFO with occupancy count. Push when full and pop |
// |            when empty are ignored. Storage is not reset; rdata is only    |
// |            meaningful while empty is low.                                  |
// | Ports    : clk, rst (sync, active high), clear (sync flush),               |
// |            push/wdata, pop/rdata, full, empty, level                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module kws_sync_fifo
    import kws_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = c_default_depth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LVL_W = level_width(DEPTH);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_level == c_FULL_LVL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule : kws_sync_fifo
`default_nettype wire

// File: rtl/kws_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : kws_frame_buffer                                                |
// | Purpose  : Captures channel-tagged audio samples strobed in asynchronously |
// |            by a host, tags every FRAME_LEN-th accepted sample as frame     |
// |            end, and buffers them for a valid/ready consumer.               |
// | Ports    : clk, rst            - clock, sync active-high reset             |
// |            in_data/in_ch       - sample word and channel tag              |
// |            in_strobe           - async level strobe, rising edge = sample |
// |            enable, ch_mask     - global and per-channel accept gates      |
// |            clear               - sync flush of FIFO and counters          |
// |            out_data/out_ch/out_last/out_valid, out_ready - head + handshake|
// |            level, overflow, frame_count - status                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module kws_frame_buffer
    import kws_pkg::*;
#(
    parameter int SAMPLE_W  = c_default_sample_w,
    parameter int N_CH      = c_default_n_ch,
    parameter int DEPTH     = c_default_depth,
    parameter int FRAME_LEN = c_default_frame_len
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_W-1:0]           in_data,
    input  logic [ch_width(N_CH)-1:0]     in_ch,
    input  logic                          in_strobe,
    input  logic                          enable,
    input  logic [N_CH-1:0]               ch_mask,
    input  logic                          clear,
    output logic [SAMPLE_W-1:0]           out_data,
    output logic [ch_width(N_CH)-1:0]     out_ch,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic [15:0]                   frame_count
);

    localparam int c_CH_W  = ch_width(N_CH);
    localparam int c_POS_W = $clog2(FRAME_LEN);
    localparam int c_ENT_W = SAMPLE_W + c_CH_W + 1;
    localparam logic [c_POS_W-1:0] c_LAST_POS = c_POS_W'(FRAME_LEN - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_hist;
    logic [c_POS_W-1:0] r_frame_pos;
    logic               r_overflow;
    logic [15:0]        r_frame_count;

    logic               w_event;
    logic               w_ch_ok;
    logic               w_accept;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_last_in;
    logic [c_ENT_W-1:0] w_wdata;
    logic [c_ENT_W-1:0] w_rdata;

    // Two flops resynchronise the strobe; the third remembers the previous
    // synchronised value so a held-high strobe yields a single event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= in_strobe;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_event = r_sync2 & ~r_hist;

    // Tags at or above N_CH match no mask bit and are rejected.
    always_comb begin
        w_ch_ok = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_ch == c_CH_W'(i) && ch_mask[i]) w_ch_ok = 1'b1;
        end
    end

    // Fullness comes from registered state, so a same-cycle pop never makes
    // room for the incoming sample.
    assign w_accept  = w_event & enable & w_ch_ok & ~clear;
    assign w_push    = w_accept & ~w_full;
    assign w_drop    = w_accept & w_full;
    assign w_last_in = (r_frame_pos == c_LAST_POS);
    assign w_wdata   = {in_data, in_ch, w_last_in};

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign out_data  = w_rdata[c_ENT_W-1:c_CH_W+1];
    assign out_ch    = w_rdata[c_CH_W:1];
    assign out_last  = w_rdata[0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_frame_pos   <= '0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_push) r_frame_pos <= w_last_in ? '0 : r_frame_pos + c_POS_W'(1);
            if (w_drop) r_overflow  <= 1'b1;
            if (w_pop && out_last) r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

    kws_sync_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

endmodule : kws_frame_buffer
`default_nettype wire

// File: tb/tb_kws_frame_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_kws_frame_buffer                                             |
// | Purpose  : Self-checking bench for kws_frame_buffer with a queue-based     |
// |            reference model and directed scenarios.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_kws_frame_buffer;

    localparam int SAMPLE_W  = 16;
    localparam int N_CH      = 2;
    localparam int DEPTH     = 32;
    localparam int FRAME_LEN = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        ch;
        logic        last;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic [0:0]  in_ch = '0;
    logic        in_strobe = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  ch_mask = 2'b11;
    logic        clear = 1'b0;
    logic [15:0] out_data;
    logic [0:0]  out_ch;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  level;
    logic        overflow;
    logic [15:0] frame_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    ent_t mq[$];
    int   m_pos = 0;
    bit   m_ovf = 1'b0;
    int   m_fc  = 0;
    bit   s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    ent_t log_q[$];

    kws_frame_buffer #(
        .SAMPLE_W  (SAMPLE_W),
        .N_CH      (N_CH),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_ch       (in_ch),
        .in_strobe   (in_strobe),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .clear       (clear),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pin level seen at edges k-2 and k-3 decides whether
    // edge k writes; the FIFO itself is an ordinary queue.
    always @(posedge clk) begin
        bit   ev, full, pop, acc;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pos = 0; m_ovf = 1'b0; m_fc = 0;
            s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        end else begin
            ev   = s2 && !s3;
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && out_ready;
            acc  = ev && enable && (int'(in_ch) < N_CH) && ch_mask[in_ch] && !clear;
            if (clear) begin
                mq.delete();
                m_pos = 0; m_ovf = 1'b0; m_fc = 0;
            end else begin
                if (pop) begin
                    if (mq[0].last) m_fc = (m_fc + 1) % 65536;
                    void'(mq.pop_front());
                end
                if (acc) begin
                    if (full) m_ovf = 1'b1;
                    else begin
                        e.data = in_data;
                        e.ch   = in_ch;
                        e.last = (m_pos == FRAME_LEN - 1);
                        mq.push_back(e);
                        m_pos = (m_pos + 1) % FRAME_LEN;
                    end
                end
            end
            s3 = s2; s2 = s1; s1 = in_strobe;
        end
    end

    // Per-cycle comparison against the model, plus a log of delivered entries.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("level", level, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("frame_count", frame_count, m_fc);
            if (mq.size() != 0 && out_valid) begin
                chk("out_data", out_data, mq[0].data);
                chk("out_ch", out_ch, mq[0].ch);
                chk("out_last", out_last, mq[0].last);
            end
            if (out_valid && out_ready) log_q.push_back({out_data, out_ch, out_last});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_ready = 1'b0; clear = 1'b0; in_strobe = 1'b0;
        enable = 1'b1; ch_mask = 2'b11;
        repeat (3) step();
        rst = 1'b0;
        step();
        log_q.delete();
    endtask

    task automatic strobe(input logic [15:0] d, input logic c);
        in_data = d; in_ch = c; in_strobe = 1'b1;
        repeat (3) step();
        in_strobe = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int n_last;
        step();
        chk_en = 1'b1;
        do_reset();

        // Reset state
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_count", frame_count, 0);

        // One full frame on ch0 with a consumer always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) strobe(16'(i), 1'b0);
        repeat (5) step();
        chk("s1_pops", log_q.size(), 16);
        n_last = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            chk("s1_data", log_q[i].data, 16'(i + 1));
            if (log_q[i].last) n_last++;
        end
        chk("s1_last_count", n_last, 1);
        if (log_q.size() == 16) chk("s1_last_pos", log_q[15].last, 1);
        chk("s1_frame_count", frame_count, 1);
        chk("s1_model_fc", m_fc, 1);

        // Overflow: 33 strobes into a 32-deep FIFO, then drain
        do_reset();
        for (int i = 0; i < 33; i++) strobe(16'h0100 + 16'(i), 1'b0);
        step();
        chk("s2_level", level, 32);
        chk("s2_overflow", overflow, 1);
        out_ready = 1'b1;
        repeat (40) step();
        chk("s2_drain_count", log_q.size(), 32);
        for (int i = 0; i < log_q.size(); i++) chk("s2_drain_data", log_q[i].data, 16'h0100 + 16'(i));
        chk("s2_frame_count", frame_count, 2);
        chk("s2_overflow_sticky", overflow, 1);

        // Channel mask plus enable gate
        do_reset();
        ch_mask = 2'b01;
        for (int i = 0; i < 8; i++) strobe(16'h0200 + 16'(i), 1'(i));
        chk("s3_level", level, 4);
        enable = 1'b0;
        strobe(16'h02FF, 1'b0);
        chk("s3_disabled_level", level, 4);
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (8) step();
        chk("s3_drain_count", log_q.size(), 4);
        for (int i = 0; i < log_q.size(); i++) begin
            chk("s3_data", log_q[i].data, 16'h0200 + 16'(2 * i));
            chk("s3_ch", log_q[i].ch, 0);
        end

        // Strobe held high for ten cycles
        do_reset();
        in_data = 16'h0333; in_ch = 1'b0; in_strobe = 1'b1;
        repeat (10) step();
        in_strobe = 1'b0;
        repeat (4) step();
        chk("s4_held_level", level, 1);

        // Full FIFO: push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 32; i++) strobe(16'h0400 + 16'(i), 1'b0);
        chk("s5_full_level", level, 32);
        in_data = 16'h4444; in_ch = 1'b0; in_strobe = 1'b1;
        step();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        in_strobe = 1'b0;
        repeat (3) step();
        chk("s5_level", level, 31);
        chk("s5_overflow", overflow, 1);
        log_q.delete();
        out_ready = 1'b1;
        repeat (40) step();
        chk("s5_drain_count", log_q.size(), 31);
        if (log_q.size() == 31) chk("s5_drain_tail", log_q[30].data, 16'h041F);

        // Clear mid-frame, then a fresh frame
        do_reset();
        for (int i = 0; i < 5; i++) strobe(16'h0500 + 16'(i), 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        chk("s6_clear_level", level, 0);
        chk("s6_clear_fc", frame_count, 0);
        out_ready = 1'b1;
        log_q.delete();
        for (int i = 0; i < 16; i++) strobe(16'h0600 + 16'(i), 1'b0);
        repeat (5) step();
        chk("s6_pops", log_q.size(), 16);
        n_last = 0;
        for (int i = 0; i < log_q.size(); i++) if (log_q[i].last) n_last++;
        chk("s6_last_count", n_last, 1);
        if (log_q.size() == 16) chk("s6_last_pos", log_q[15].last, 1);
        chk("s6_frame_count", frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_kws_frame_buffer
`default_nettype wire

// File: doc/kws_frame_buffer.md
KWS_FRAME_BUFFER -- requirements
Module: kws_frame_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning bits per audio sample.
REQ-002 SHALL have parameter N_CH, default 2 (legal 1..4), meaning number of tagged input channels.
REQ-003 SHALL have parameter DEPTH, default 32 (power of 2, >=4), meaning FIFO entries.
REQ-004 SHALL have parameter FRAME_LEN, default 16 (>=2), meaning samples per frame.
REQ-005 SHALL have port clk, input, 1, the single clock; one clock, no other clock domain.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_data, input, SAMPLE_W, sample word driven by the host over logic-analyser pins.
REQ-008 SHALL have port in_ch, input, CH_W=max(1,clog2(N_CH)), channel tag of in_data.
REQ-009 SHALL have port in_strobe, input, 1, asynchronous level strobe; each rising edge means one new sample.
REQ-010 SHALL have port enable, input, 1, accept strobes when high.
REQ-011 SHALL have port ch_mask, input, N_CH, per-channel accept mask.
REQ-012 SHALL have port clear, input, 1, synchronous flush.
REQ-013 SHALL have port out_data, output, SAMPLE_W, head sample.
REQ-014 SHALL have port out_ch, output, CH_W, head channel tag.
REQ-015 SHALL have port out_last, output, 1, head is final sample of a frame.
REQ-016 SHALL have port out_valid, output, 1, head valid.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-018 SHALL have port level, output, clog2(DEPTH)+1, current occupancy.
REQ-019 SHALL have port overflow, output, 1, sticky dropped-sample flag.
REQ-020 SHALL have port frame_count, output, 16, frames delivered, wraps modulo 2^16.

Function
REQ-021 SHALL pass in_strobe through a 2-flop synchroniser plus a third history flop; accept event = sync2 & ~hist.
REQ-022 SHALL sample in_data/in_ch on the accept-event cycle; write occurs in that cycle, visible on out_valid the next cycle (3-4 clk from pin edge).
REQ-023 SHALL discard an event when enable=0, ch_mask[in_ch]=0, or in_ch>=N_CH; no state change.
REQ-024 SHALL count accepted samples in frame_pos 0..FRAME_LEN-1; entry written with last=1 when frame_pos=FRAME_LEN-1, then frame_pos wraps to 0.
REQ-025 SHALL judge full from registered state at cycle start; event when full is dropped, overflow set, frame_pos unchanged, even if a pop occurs the same cycle.
REQ-026 SHALL drive out_valid = (level!=0); out_data/out_ch/out_last = head entry; no same-cycle write-to-read bypass.
REQ-027 SHALL pop on out_valid & out_ready; simultaneous push and pop keeps level unchanged.
REQ-028 SHALL hold head stable while out_valid & ~out_ready.
REQ-029 SHALL increment frame_count on each pop with out_last=1.
REQ-030 SHALL on clear: empty FIFO, frame_pos=0, overflow=0, frame_count=0; a coincident event is discarded; synchroniser flops unaffected.

Reset
REQ-031 SHALL on rst=1 at a clk edge: pointers, level, frame_pos, frame_count=0; overflow=0; out_valid=0; synchroniser/history flops=0.
REQ-032 SHALL treat rst mid-frame or mid-stall as full abort; partial frame is lost, no last emitted.
REQ-033 SHALL not require FIFO storage array to be reset; out_data/out_ch/out_last are don't-care while out_valid=0.

Structure
REQ-034 SHALL place CH_W/level-width helper functions and default parameter constants in shared package kws_pkg.
REQ-035 SHALL implement storage as one sub-module kws_sync_fifo (parametrised width SAMPLE_W+CH_W+1, DEPTH, push/pop/full/empty/level).
REQ-036 SHALL keep synchroniser, frame counter and mask logic in kws_frame_buffer.

Verification
REQ-037 SHALL test: FRAME_LEN=16, ch_mask=2'b11, 16 strobes ch0 data 0x0001..0x0010, out_ready=1 -> 16 pops, last only on 0x0010, frame_count=1.
REQ-038 SHALL test: out_ready=0, DEPTH=32, 33 strobes -> level=32, overflow=1, 33rd sample absent; drain yields 32 in order.
REQ-039 SHALL test: ch_mask=2'b01, alternating ch0/ch1 strobes x8 -> only 4 ch0 samples stored, level=4.
REQ-040 SHALL test: strobe held high 10 cycles -> exactly one sample written.
REQ-041 SHALL test: FIFO full, push and pop same cycle -> level stays 31 after pop-only accounting (push dropped), overflow=1.
REQ-042 SHALL test: clear asserted after 5 of 16 samples, then 16 new strobes -> level=0 post-clear, new frame last on 16th new sample, frame_count=1.
